// File: rtl/gamma_lut_ram_if.sv
// Pixel stream and table-configuration bundle for gamma_lut_ram.
// The master side is the video source / host; the slave side is the LUT block.
interface gamma_lut_ram_if #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 12
);
    // There is no valid/ready pair: I_de qualifies a pixel on every clock and the
    // block never stalls, so O_de simply trails I_de by the pipeline depth.
    logic                      I_vs;
    logic                      I_hs;
    logic                      I_de;
    logic [CHANNELS*IN_W-1:0]  I_data;
    logic                      I_cfg_we;
    logic [IN_W-1:0]           I_cfg_addr;
    logic [OUT_W-1:0]          I_cfg_data;
    logic                      I_cfg_commit;
    logic                      I_bypass;
    logic                      O_vs;
    logic                      O_hs;
    logic                      O_de;
    logic [CHANNELS*OUT_W-1:0] O_data;
    logic                      O_init_done;
    logic                      O_cfg_busy;
    logic                      O_commit_ack;
    logic [1:0]                O_dbg_state;

    modport master (
        output I_vs, I_hs, I_de, I_data, I_cfg_we, I_cfg_addr, I_cfg_data,
               I_cfg_commit, I_bypass,
        input  O_vs, O_hs, O_de, O_data, O_init_done, O_cfg_busy, O_commit_ack,
               O_dbg_state
    );

    modport slave (
        input  I_vs, I_hs, I_de, I_data, I_cfg_we, I_cfg_addr, I_cfg_data,
               I_cfg_commit, I_bypass,
        output O_vs, O_hs, O_de, O_data, O_init_done, O_cfg_busy, O_commit_ack,
               O_dbg_state
    );
endinterface

// File: rtl/gamma_lut_ram.sv
// Double-buffered, runtime-loadable gamma LUT; the shadow bank swaps in on a frame start.
// Optional identity bypass is compiled in with GAMMA_LUT_BYPASS_EN.
module gamma_lut_ram #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 12
) (
    input  logic           I_clk,
    input  logic           I_rst,
    gamma_lut_ram_if.slave bus
);
    localparam int DEPTH = 1 << IN_W;
    localparam int SH    = OUT_W - IN_W;
    localparam int DW    = CHANNELS * IN_W;
    localparam int OW    = CHANNELS * OUT_W;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] id_map(input logic [IN_W-1:0] x);
        return OUT_W'(x) << SH;
    endfunction

    state_t           state_q, state_d;
    logic             act_bank_q, act_bank_d;
    logic [IN_W-1:0]  fill_q, fill_d;
    logic             vs_prev_q, vs_prev_d;
    logic             init_done_q, init_done_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;

    logic             wr_both, wr_shadow;
    logic [IN_W-1:0]  wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic             use_id;

    logic             vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d, use_id1_q, use_id1_d;
    logic [DW-1:0]    data1_q, data1_d;
    logic [OUT_W-1:0] rd1_q [CHANNELS];
    logic [OUT_W-1:0] rd1_d [CHANNELS];
    logic             vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d;
    logic [OW-1:0]    out_q, out_d;

    logic [OUT_W-1:0] mem_q [CHANNELS][2][DEPTH];

    always_comb begin
        state_d     = state_q;
        act_bank_d  = act_bank_q;
        fill_d      = fill_q;
        init_done_d = init_done_q;
        ack_d       = 1'b0;
        vs_prev_d   = bus.I_vs;
        wr_both     = 1'b0;
        wr_shadow   = 1'b0;
        wr_addr     = fill_q;
        wr_data     = id_map(fill_q);
        case (state_q)
            ST_INIT: begin
                wr_both = 1'b1;
                fill_d  = fill_q + 1'b1;
                if (&fill_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.I_cfg_we) begin
                    wr_shadow = 1'b1;
                    wr_addr   = bus.I_cfg_addr;
                    wr_data   = bus.I_cfg_data;
                end
                if (bus.I_cfg_commit) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (bus.I_vs && !vs_prev_q) begin
                    act_bank_d = ~act_bank_q;
                    ack_d      = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase
        busy_d = (state_d != ST_RUN);
    end

    // Reads follow the bank selected for this cycle, so a pixel on the swap edge sees the new curve.
    always_comb begin
        use_id = (state_q == ST_INIT);
`ifdef GAMMA_LUT_BYPASS_EN
        use_id = use_id | bus.I_bypass;
`endif
        vs1_d     = bus.I_vs;
        hs1_d     = bus.I_hs;
        de1_d     = bus.I_de;
        data1_d   = bus.I_data;
        use_id1_d = use_id;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            rd1_d[ch] = mem_q[ch][act_bank_d][bus.I_data[ch*IN_W +: IN_W]];
        end
        vs2_d = vs1_q;
        hs2_d = hs1_q;
        de2_d = de1_q;
        out_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            out_d[ch*OUT_W +: OUT_W] = use_id1_q ? id_map(data1_q[ch*IN_W +: IN_W]) : rd1_q[ch];
        end
    end

`ifndef GAMMA_LUT_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = bus.I_bypass;
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= ST_INIT;
            act_bank_q  <= 1'b0;
            fill_q      <= '0;
            vs_prev_q   <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            ack_q       <= 1'b0;
            vs1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            de1_q       <= 1'b0;
            use_id1_q   <= 1'b0;
            data1_q     <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) rd1_q[ch] <= '0;
            vs2_q       <= 1'b0;
            hs2_q       <= 1'b0;
            de2_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            act_bank_q  <= act_bank_d;
            fill_q      <= fill_d;
            vs_prev_q   <= vs_prev_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            vs1_q       <= vs1_d;
            hs1_q       <= hs1_d;
            de1_q       <= de1_d;
            use_id1_q   <= use_id1_d;
            data1_q     <= data1_d;
            for (int ch = 0; ch < CHANNELS; ch++) rd1_q[ch] <= rd1_d[ch];
            vs2_q       <= vs2_d;
            hs2_q       <= hs2_d;
            de2_q       <= de2_d;
            out_q       <= out_d;
        end
    end

    // Every channel copy receives the same write; only the shadow bank is touched outside INIT.
    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int b = 0; b < 2; b++) begin
                    if (wr_both || (wr_shadow && (1'(b) != act_bank_q))) begin
                        mem_q[ch][b][wr_addr] <= wr_data;
                    end
                end
            end
        end
    end

    assign bus.O_vs         = vs2_q;
    assign bus.O_hs         = hs2_q;
    assign bus.O_de         = de2_q;
    assign bus.O_data       = out_q;
    assign bus.O_init_done  = init_done_q;
    assign bus.O_cfg_busy   = busy_q;
    assign bus.O_commit_ack = ack_q;
    assign bus.O_dbg_state  = state_q;
endmodule

// File: tb/tb_gamma_lut_ram.sv
// Randomised scoreboard bench for gamma_lut_ram against a curve-level reference model.
// Build with GAMMA_LUT_BYPASS_EN defined to exercise the bypass path.
module tb_gamma_lut_ram;
  localparam int CHANNELS = 3;
  localparam int IN_W     = 8;
  localparam int OUT_W    = 12;
  localparam int DEPTH    = 256;
  localparam int SH       = OUT_W - IN_W;
  localparam int EW       = 2 + CHANNELS * OUT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gamma_lut_ram_if #(.CHANNELS(CHANNELS), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gamma_lut_ram #(.CHANNELS(CHANNELS), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            ack_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // reference model: two curves, which one is live, and a pending-swap flag
  int curve[DEPTH];
  int bank[2][DEPTH];
  int act;
  bit pending;
  bit vs_prev;
  int beat_k;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic int id_of(input int x);
    return x << SH;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) bank[b][i] = id_of(i);
    act     = 0;
    pending = 1'b0;
    vs_prev = 1'b0;
    beat_k  = 0;
  endtask

  // driver: one input beat, model update, one clock
  task automatic beat(input bit vs, input bit hs, input bit de,
                      input logic [CHANNELS*IN_W-1:0] data,
                      input bit we, input int addr, input int wd,
                      input bit commit, input bit byp);
    bit                        in_run, pend0, byp_eff;
    logic [CHANNELS*OUT_W-1:0] e;
    int                        x;
    bus.I_vs         = vs;
    bus.I_hs         = hs;
    bus.I_de         = de;
    bus.I_data       = data;
    bus.I_cfg_we     = we;
    bus.I_cfg_addr   = IN_W'(addr);
    bus.I_cfg_data   = OUT_W'(wd);
    bus.I_cfg_commit = commit;
    bus.I_bypass     = byp;
`ifdef GAMMA_LUT_BYPASS_EN
    byp_eff = byp;
`else
    byp_eff = 1'b0;
`endif
    in_run = (beat_k >= DEPTH);
    pend0  = pending;
    if (in_run && pending && vs && !vs_prev) begin
      act     = act ^ 1;
      pending = 1'b0;
      ack_q.push_back(cyc + 1);
    end
    if (de) begin
      e = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        x = int'(data[ch*IN_W +: IN_W]);
        e[ch*OUT_W +: OUT_W] = OUT_W'((!in_run || byp_eff) ? id_of(x) : bank[act][x]);
      end
      exp_q.push_back({vs, hs, e});
    end
    if (in_run && !pend0 && we) bank[act ^ 1][addr] = wd;
    if (in_run && !pend0 && commit) pending = 1'b1;
    vs_prev = vs;
    beat_k++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  function automatic logic [CHANNELS*IN_W-1:0] rand_pix();
    logic [CHANNELS*IN_W-1:0] p;
    for (int ch = 0; ch < CHANNELS; ch++) p[ch*IN_W +: IN_W] = IN_W'($urandom_range(0, DEPTH - 1));
    return p;
  endfunction

  task automatic do_reset();
    repeat (3) idle();
    check("drain_before_reset", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_init_done", 64'(bus.O_init_done), 64'd0);
    check("rst_cfg_busy", 64'(bus.O_cfg_busy), 64'd1);
    check("rst_o_de", 64'(bus.O_de), 64'd0);
    check("rst_o_vs", 64'(bus.O_vs), 64'd0);
    check("rst_o_data", 64'(bus.O_data), 64'd0);
    check("rst_commit_ack", 64'(bus.O_commit_ack), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // INIT window with random traffic; config strobes here must be ignored
  task automatic run_init();
    logic [CHANNELS*IN_W-1:0] p;
    for (int n = 1; n <= DEPTH; n++) begin
      p = rand_pix();
      if (n == 11) p[IN_W-1:0] = 8'h80;
      beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (n == 11) ? 1'b1 : 1'($urandom_range(0, 1)),
           p, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 4095),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      check("init_done", 64'(bus.O_init_done), 64'(n >= DEPTH));
      check("cfg_busy", 64'(bus.O_cfg_busy), 64'(n < DEPTH));
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a pixel or an ack
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst !== 1'b1) begin
      if (bus.O_de === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pixel: got data 0x%0h with no expectation queued (cycle %0d)", bus.O_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pixel_vs_hs_data", 64'({bus.O_vs, bus.O_hs, bus.O_data}), 64'(e));
        end
      end
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
        void'(ack_q.pop_front());
        check("commit_ack", 64'(bus.O_commit_ack), 64'd1);
      end else if (bus.O_commit_ack !== 1'b0) begin
        n_checks++;
        $display("FAIL unexpected_commit_ack: got %b, expected 0 (cycle %0d)", bus.O_commit_ack, cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) curve[i] = $rtoi($sqrt((i + 0.5) / 256.0) * 4095.0 + 0.5);
    bus.I_vs = 1'b0; bus.I_hs = 1'b0; bus.I_de = 1'b0; bus.I_data = '0;
    bus.I_cfg_we = 1'b0; bus.I_cfg_addr = '0; bus.I_cfg_data = '0;
    bus.I_cfg_commit = 1'b0; bus.I_bypass = 1'b0;
    model_reset();

    do_reset();
    run_init();

    // load gamma 2.0, commit, identity until the frame edge, curve from it
    for (int i = 0; i < DEPTH; i++)
      beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_pix(), 1'b1, i, curve[i], 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b1, {8'h40, 8'hFF, 8'h00}, 1'b0, 0, 0, 1'b1, 1'b0);
    repeat (3) beat(1'b0, 1'b1, 1'b1, {8'h40, 8'hFF, 8'h00}, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1, {8'h40, 8'hFF, 8'h00}, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) beat(1'b1, 1'b1, 1'b1, {8'h40, 8'hFF, 8'h00}, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b1, {8'h10, 8'h80, 8'h01}, 1'b0, 0, 0, 1'b0, 1'b0);

    // write during PEND is dropped; two swaps bring the gamma bank back untouched
    beat(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b1, {8'h10, 8'h10, 8'h10}, 1'b1, 8'h10, 12'hFFF, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, {8'h10, 8'h10, 8'h10}, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b1, {8'h10, 8'h10, 8'h10}, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1, {8'h10, 8'h10, 8'h10}, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b1, {8'hFF, 8'h7F, 8'h00}, 1'b0, 0, 0, 1'b0, 1'b0);

    // bypass request: identity only when the feature is built in
    repeat (2) beat(1'b0, 1'b0, 1'b1, {8'h40, 8'h40, 8'h40}, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (2) beat(1'b0, 1'b0, 1'b1, {8'h40, 8'h40, 8'h40}, 1'b0, 0, 0, 1'b0, 1'b0);

    // random traffic: writes, commits, frame edges, bypass
    for (int n = 0; n < 700; n++)
      beat(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), rand_pix(),
           ($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1), $urandom_range(0, 4095),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0));

    // reset while a commit is pending: no swap afterwards, identity restored
    beat(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h20, 12'h123, 1'b1, 1'b0);
    check("pend_before_reset", 64'(bus.O_cfg_busy), 64'd1);
    do_reset();
    run_init();
    beat(1'b0, 1'b0, 1'b1, {8'h20, 8'h7F, 8'hFF}, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) beat(1'b1, 1'b0, 1'b1, {8'h20, 8'h7F, 8'hFF}, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (4) beat(1'b0, 1'b1, 1'b1, rand_pix(), 1'b0, 0, 0, 1'b0, 1'b0);

    repeat (4) idle();
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("ack_queue_empty", 64'(ack_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
